// File: rtl/bank_linefill_mshr.sv
// Miss-status holding registers and linefill sequencer for one cache bank:
// one BIU read per missing line, two 128-bit beats assembled into a 256-bit line.
module bank_linefill_mshr #(
  parameter int MSHR_NUM = 4,
  parameter int ID_WIDTH = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                alloc_valid_i,
  output logic                alloc_ready_o,
  input  logic [ID_WIDTH-1:0] alloc_line_id_i,
  input  logic [ID_WIDTH-1:0] lookup_line_id_i,
  output logic                lookup_inflight_o,
  output logic                biu_ar_valid_o,
  input  logic                biu_ar_ready_i,
  output logic [ID_WIDTH-1:0] biu_ar_id_o,
  input  logic                biu_r_valid_i,
  input  logic [ID_WIDTH-1:0] biu_r_id_i,
  input  logic [127:0]        biu_r_data_i,
  input  logic                biu_r_last_i,
  output logic                lfb_wen_o,
  output logic [ID_WIDTH-1:0] lfb_waddr_o,
  output logic [255:0]        lfb_wdata_o,
  output logic                isu_rvalid_o,
  output logic [ID_WIDTH-1:0] isu_rid_o,
  output logic                err_o
);

  localparam int IDX_W = $clog2(MSHR_NUM);

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_BEAT0 = 2'd2,
    ST_BEAT1 = 2'd3
  } ent_state_e;

  ent_state_e          state_r   [MSHR_NUM];
  logic [ID_WIDTH-1:0] line_id_r [MSHR_NUM];
  logic [127:0]        beat0_r   [MSHR_NUM];
  logic [IDX_W-1:0]    rr_ptr_r;
  logic [IDX_W-1:0]    lock_idx_r;
  logic                lock_r;

  logic                alloc_match_s;
  logic                free_any_s;
  logic [IDX_W-1:0]    free_idx_s;
  logic                inflight_s;
  logic                any_req_s;
  logic [IDX_W-1:0]    cand_s;
  logic [IDX_W-1:0]    rr_pick_s;
  logic [IDX_W-1:0]    grant_idx_s;
  logic                resp_hit_s;
  logic [IDX_W-1:0]    resp_idx_s;

  // Entry search: allocation match/free slot, lookup probe, RR pick, response target.
  always_comb begin
    alloc_match_s = 1'b0;
    free_any_s    = 1'b0;
    free_idx_s    = {IDX_W{1'b0}};
    inflight_s    = 1'b0;
    any_req_s     = 1'b0;
    cand_s        = {IDX_W{1'b0}};
    rr_pick_s     = {IDX_W{1'b0}};
    resp_hit_s    = 1'b0;
    resp_idx_s    = {IDX_W{1'b0}};
    // Descending scans let the lowest index (or lowest RR offset) win.
    for (int i = MSHR_NUM - 1; i >= 0; i--) begin
      free_any_s    = free_any_s | (state_r[i] == ST_FREE);
      free_idx_s    = (state_r[i] == ST_FREE) ? IDX_W'(i) : free_idx_s;
      alloc_match_s = alloc_match_s |
                      ((state_r[i] != ST_FREE) && (line_id_r[i] == alloc_line_id_i));
      inflight_s    = inflight_s |
                      ((state_r[i] != ST_FREE) && (line_id_r[i] == lookup_line_id_i));
      any_req_s     = any_req_s | (state_r[i] == ST_REQ);
      resp_hit_s    = resp_hit_s | (((state_r[i] == ST_BEAT0) || (state_r[i] == ST_BEAT1))
                                    && (line_id_r[i] == biu_r_id_i));
      resp_idx_s    = (((state_r[i] == ST_BEAT0) || (state_r[i] == ST_BEAT1))
                       && (line_id_r[i] == biu_r_id_i)) ? IDX_W'(i) : resp_idx_s;
      cand_s        = rr_ptr_r + IDX_W'(i);
      rr_pick_s     = (state_r[cand_s] == ST_REQ) ? cand_s : rr_pick_s;
    end
    grant_idx_s = lock_r ? lock_idx_r : rr_pick_s;
  end

  assign alloc_ready_o     = free_any_s | alloc_match_s;
  assign lookup_inflight_o = inflight_s;
  assign biu_ar_valid_o    = any_req_s;
  assign biu_ar_id_o       = any_req_s ? line_id_r[grant_idx_s] : {ID_WIDTH{1'b0}};

  // Entry state machines, request grant lock, and registered completion/error outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MSHR_NUM; i++) begin
        state_r[i]   <= ST_FREE;
        line_id_r[i] <= {ID_WIDTH{1'b0}};
        beat0_r[i]   <= 128'd0;
      end
      rr_ptr_r     <= {IDX_W{1'b0}};
      lock_idx_r   <= {IDX_W{1'b0}};
      lock_r       <= 1'b0;
      lfb_wen_o    <= 1'b0;
      lfb_waddr_o  <= {ID_WIDTH{1'b0}};
      lfb_wdata_o  <= 256'd0;
      isu_rvalid_o <= 1'b0;
      isu_rid_o    <= {ID_WIDTH{1'b0}};
      err_o        <= 1'b0;
    end else begin
      lfb_wen_o    <= 1'b0;
      isu_rvalid_o <= 1'b0;

      if (alloc_valid_i && alloc_ready_o && !alloc_match_s) begin
        state_r[free_idx_s]   <= ST_REQ;
        line_id_r[free_idx_s] <= alloc_line_id_i;
      end

      // The grant stays locked while the request waits, so the AR id cannot change.
      if (any_req_s && biu_ar_ready_i) begin
        state_r[grant_idx_s] <= ST_BEAT0;
        rr_ptr_r             <= grant_idx_s + 1'b1;
        lock_r               <= 1'b0;
      end else if (any_req_s) begin
        lock_r     <= 1'b1;
        lock_idx_r <= grant_idx_s;
      end else begin
        lock_r <= 1'b0;
      end

      if (biu_r_valid_i) begin
        if (!resp_hit_s) begin
          err_o <= 1'b1;
        end else begin
          case (state_r[resp_idx_s])
            ST_BEAT0: begin
              if (biu_r_last_i) begin
                err_o <= 1'b1;
              end else begin
                beat0_r[resp_idx_s] <= biu_r_data_i;
                state_r[resp_idx_s] <= ST_BEAT1;
              end
            end
            ST_BEAT1: begin
              if (biu_r_last_i) begin
                state_r[resp_idx_s] <= ST_FREE;
                lfb_wen_o           <= 1'b1;
                isu_rvalid_o        <= 1'b1;
                lfb_waddr_o         <= line_id_r[resp_idx_s];
                isu_rid_o           <= line_id_r[resp_idx_s];
                lfb_wdata_o         <= {biu_r_data_i, beat0_r[resp_idx_s]};
              end else begin
                err_o <= 1'b1;
              end
            end
            default: err_o <= 1'b1;
          endcase
        end
      end
    end
  end

endmodule
